// File: rtl/resistor_capacitor_high_pass_filter.sv
// RC high-pass (capacitor-coupling) stage: y[n] = ALPHA*(y[n-1] + x[n] - x[n-1]),
// one sequential 17-step shift-add multiply per audio sample.
module resistor_capacitor_high_pass_filter #(
  parameter int     SAMPLE_RATE  = 48000,
  parameter longint R            = 47000,
  parameter longint C_35_SHIFTED = 1615
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               audio_clk_en,
  input  logic signed [15:0] in,
  output logic signed [15:0] out,
  output logic               out_valid,
  output logic               busy,
  output logic               overrun
);

  localparam longint RC       = R * C_35_SHIFTED;
  localparam longint DT_35    = (64'sd1 <<< 35) / SAMPLE_RATE;
  localparam longint ALPHA_L  = (RC <<< 16) / (RC + DT_35);
  localparam logic [16:0] ALPHA_16 = ALPHA_L[16:0];
  localparam int     MUL_STEPS = 17;

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

  state_t             state_q, state_d;
  logic signed [15:0] out_q, out_d;
  logic signed [15:0] x_prev_q, x_prev_d;
  logic               out_valid_q, out_valid_d;
  logic               overrun_q, overrun_d;
  logic signed [34:0] mcand_q, mcand_d;
  logic        [16:0] mpr_q, mpr_d;
  logic signed [34:0] acc_q, acc_d;
  logic        [4:0]  cnt_q, cnt_d;

  logic signed [17:0] sum;
  logic signed [34:0] shr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      out_q       <= '0;
      x_prev_q    <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      mcand_q     <= '0;
      mpr_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      x_prev_q    <= x_prev_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      mcand_q     <= mcand_d;
      mpr_q       <= mpr_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  // 18 bits holds the full-scale range of out + in - x_prev without wrap.
  assign sum = {{2{out_q[15]}}, out_q} + {{2{in[15]}}, in} - {{2{x_prev_q[15]}}, x_prev_q};
  assign shr = acc_q >>> 16;

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    x_prev_d    = x_prev_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;
    mcand_d     = mcand_q;
    mpr_d       = mpr_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;

    if (audio_clk_en && state_q != IDLE) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (audio_clk_en) begin
          x_prev_d = in;
          mcand_d  = {{17{sum[17]}}, sum};
          mpr_d    = ALPHA_16;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = MULT;
        end
      end
      MULT: begin
        if (mpr_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = mcand_q <<< 1;
        mpr_d   = mpr_q >> 1;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'(MUL_STEPS - 1)) state_d = DONE;
      end
      DONE: begin
        // Floor shift first, clip afterwards; the product itself never overflows.
        if (shr > 35'sd32767)       out_d = 16'sh7fff;
        else if (shr < -35'sd32768) out_d = 16'sh8000;
        else                        out_d = shr[15:0];
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule
